hit_judge: RTL and testbench
============================

// Module: hit_judge
// PURPOSE
//   Consumes the 9-bit one-hot mole lights from the light controller and the
//   decoded key presses from the keypad controller, and judges every light
//   flick as a hit or a miss. Keeps score, miss and flick counters and raises
//   game_over/win to the wam top level. Sits downstream of both controllers.
// PARAMETERS
//   N_HOLES   9   number of lights/keys; key_index range 0..N_HOLES-1
//   CNT_W     6   width of score/misses/flicks counters and total_points
// PORTS
//   clk           in   1      system clock (CLOCK_50)
//   reset         in   1      asynchronous, active-low; clears all state
//   lights        in   9      light controller output; one-hot = lit, else dark
//   key_valid     in   1      single-cycle pulse: a key press is presented
//   key_index     in   4      pressed key 0..8; values 9..15 ignored
//   total_points  in   CNT_W  flicks per game (25 or 50 from SW[5])
//   deathmatch    in   1      1 = first miss ends the game
//   score         out  CNT_W  hits this game
//   misses        out  CNT_W  misses this game
//   flicks        out  CNT_W  completed light episodes this game
//   hit_pulse     out  1      one-cycle pulse per judged hit
//   miss_pulse    out  1      one-cycle pulse per judged miss
//   game_over     out  1      level; high from game end until reset
//   win           out  1      valid while game_over=1
// BEHAVIOUR
//   - Reset (reset=0): all outputs 0, FSM -> DARK, lit_mask=0, judged=0.
//   - All outputs registered. Everything below is evaluated at a rising edge
//     using that cycle's inputs; results visible immediately after the edge.
//   - Multi-hot or all-zero lights = dark. Episode = interval with one stable
//     one-hot lights value; latched in lit_mask at episode start.
//   - FSM states: DARK, LIT, DONE.
//     DARK: lights one-hot -> LIT, lit_mask<=lights, judged<=0.
//     LIT : lights != lit_mask -> episode end: flicks+1; if judged=0 ->
//           miss (misses+1, miss_pulse). Then -> LIT with new mask if lights
//           is one-hot, else -> DARK. Game-end check (below) has priority.
//     DONE: terminal; counters frozen, inputs ignored, pulses 0, until reset.
//   - Key judging (key_valid=1, key_index<=8, state LIT, judged=0):
//     key matches lit_mask -> hit: score+1, hit_pulse, judged<=1.
//     key mismatches -> miss: misses+1, miss_pulse, judged<=1 (episode dead).
//     Press with judged=1, in DARK, or key_index>8: ignored, no pulse.
//   - Simultaneous press and episode end: press judged against the ENDING
//     episode (old lit_mask) first; end-of-episode miss only if still unjudged.
//     Net at most one pulse and one counter increment per episode end cycle.
//   - Game end: flicks (post-update) == total_points -> DONE, game_over=1,
//     win = (2*score >= total_points). deathmatch=1 and misses becomes 1 ->
//     DONE same edge, win=0. total_points=0 -> DONE at first edge after reset
//     release, win=1.
//   - Counters saturate at 2^CNT_W-1; no wrap.
//   - Latency: key_valid sampled at edge N -> hit_pulse/miss_pulse high for
//     exactly the cycle after edge N.
//   - Asynchronous reset mid-game: immediate clear, episode in flight discarded.
// TESTING
//   1 lights=0x010 for 10 cycles, key_index=4 pulse at cycle 3 -> hit_pulse
//     next cycle, score=1; lights->0 -> flicks=1, misses=0.
//   2 lights=0x001, key_index=2 pulse, then key_index=0 pulse -> one
//     miss_pulse only, misses=1, score=0; lights->0 -> no further miss.
//   3 lights=0x100 -> 0x002 directly, key_index=8 on the change edge -> hit
//     credited to old episode, score=1, flicks=1, new episode unjudged.
//   4 total_points=25, 25 episodes with 13 hits -> game_over=1, win=1 on the
//     25th end edge; further lights/keys leave score=13, flicks=25.
//   5 deathmatch=1, lights=0x020 ends with no press -> misses=1, game_over=1,
//     win=0 same edge.
//   6 reset=0 asserted mid-LIT with score=5 -> all outputs 0 asynchronously;
//     key_index=12 presses never change any counter.

Source files
------------

// File: rtl/hit_judge.sv
// hit_judge: judges each mole-light episode as a hit or a miss.
// It keeps the score, miss and flick counters, and raises game_over and win.
module hit_judge #(
    parameter int N_HOLES = 9,
    parameter int CNT_W   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_HOLES-1:0] lights,
    input  logic               key_valid,
    input  logic [3:0]         key_index,
    input  logic [CNT_W-1:0]   total_points,
    input  logic               deathmatch,
    output logic [CNT_W-1:0]   score,
    output logic [CNT_W-1:0]   misses,
    output logic [CNT_W-1:0]   flicks,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               game_over,
    output logic               win
);

    typedef enum logic [1:0] {DARK, LIT, DONE} state_t;

    state_t             state, state_n;
    logic [N_HOLES-1:0] lit_mask, mask_n;
    logic               judged, judged_n;
    logic [CNT_W-1:0]   score_n, misses_n, flicks_n;
    logic               hit_n, miss_n, over_n, win_n;
    logic               press, light_ok;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Only exactly one lit hole counts as a live light; anything else is dark.
    function automatic logic is_onehot(input logic [N_HOLES-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // Next-state, judging and game-end decisions for this edge.
    always_comb begin
        state_n  = state;
        mask_n   = lit_mask;
        judged_n = judged;
        score_n  = score;
        misses_n = misses;
        flicks_n = flicks;
        hit_n    = 1'b0;
        miss_n   = 1'b0;
        over_n   = game_over;
        win_n    = win;
        press    = key_valid && (int'(key_index) < N_HOLES);
        light_ok = is_onehot(lights);

        case (state)
            DARK: begin
                if (light_ok) begin
                    state_n  = LIT;
                    mask_n   = lights;
                    judged_n = 1'b0;
                end
            end
            LIT: begin
                // A press is always judged against the episode that was lit
                // going into this edge, even if that episode ends here.
                if (press && !judged) begin
                    if (lit_mask[key_index]) hit_n = 1'b1;
                    else                     miss_n = 1'b1;
                    judged_n = 1'b1;
                end
                if (lights != lit_mask) begin
                    flicks_n = sat_inc(flicks);
                    if (!judged && !hit_n && !miss_n) miss_n = 1'b1;
                    judged_n = 1'b0;
                    if (light_ok) mask_n = lights;
                    else          state_n = DARK;
                end
            end
            default: begin
                state_n = DONE;
            end
        endcase

        if (hit_n)  score_n  = sat_inc(score);
        if (miss_n) misses_n = sat_inc(misses);

        // The game-end check overrides the light-driven next state.
        if (state != DONE) begin
            if (deathmatch && miss_n && (misses == '0)) begin
                state_n = DONE;
                over_n  = 1'b1;
                win_n   = 1'b0;
            end else if (flicks_n == total_points) begin
                state_n = DONE;
                over_n  = 1'b1;
                win_n   = ({score_n, 1'b0} >= {1'b0, total_points});
            end
        end
    end

    // Register all state and outputs; reset discards any episode in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= DARK;
            lit_mask   <= '0;
            judged     <= 1'b0;
            score      <= '0;
            misses     <= '0;
            flicks     <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            game_over  <= 1'b0;
            win        <= 1'b0;
        end else begin
            state      <= state_n;
            lit_mask   <= mask_n;
            judged     <= judged_n;
            score      <= score_n;
            misses     <= misses_n;
            flicks     <= flicks_n;
            hit_pulse  <= hit_n;
            miss_pulse <= miss_n;
            game_over  <= over_n;
            win        <= win_n;
        end
    end

endmodule

// File: tb/tb_hit_judge.sv
// Testbench for hit_judge: directed game scenarios plus randomized games,
// checked every cycle against an episode-level reference model.
module tb_hit_judge;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] lights = '0;
    logic       key_valid = 1'b0;
    logic [3:0] key_index = '0;
    logic [5:0] total_points = 6'd25;
    logic       deathmatch = 1'b0;
    logic [5:0] score, misses, flicks;
    logic       hit_pulse, miss_pulse, game_over, win;

    int nvec = 0;
    int nbad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    hit_judge #(.N_HOLES(9), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .lights(lights), .key_valid(key_valid),
        .key_index(key_index), .total_points(total_points), .deathmatch(deathmatch),
        .score(score), .misses(misses), .flicks(flicks), .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse), .game_over(game_over), .win(win)
    );

    // Reference model: the current episode is the index of the lit hole (-1 when dark).
    int m_score, m_misses, m_flicks, ep, cur, prev_misses;
    bit m_hit, m_miss, m_over, m_win, ep_judged, m_press;

    function automatic int lit_idx(input logic [8:0] l);
        if ($countones(l) != 1) return -1;
        for (int i = 0; i < 9; i++) if (l[i]) return i;
        return -1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_score = 0; m_misses = 0; m_flicks = 0; ep = -1; ep_judged = 0;
            m_hit = 0; m_miss = 0; m_over = 0; m_win = 0;
        end else begin
            m_hit = 0;
            m_miss = 0;
            if (!m_over) begin
                cur = lit_idx(lights);
                m_press = key_valid && (key_index < 9);
                prev_misses = m_misses;
                if (ep >= 0 && m_press && !ep_judged) begin
                    if (int'(key_index) == ep) m_hit = 1; else m_miss = 1;
                    ep_judged = 1;
                end
                if (ep >= 0 && cur != ep) begin
                    m_flicks = (m_flicks < 63) ? m_flicks + 1 : 63;
                    if (!ep_judged) m_miss = 1;
                    ep = cur;
                    ep_judged = 0;
                end else if (ep < 0 && cur >= 0) begin
                    ep = cur;
                    ep_judged = 0;
                end
                if (m_hit)  m_score  = (m_score < 63) ? m_score + 1 : 63;
                if (m_miss) m_misses = (m_misses < 63) ? m_misses + 1 : 63;
                if (deathmatch && m_miss && prev_misses == 0) begin
                    m_over = 1; m_win = 0;
                end else if (m_flicks == int'(total_points)) begin
                    m_over = 1; m_win = (2 * m_score >= int'(total_points));
                end
            end
        end
    end

    // Compare every output against the model in the middle of each cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            nvec++;
            if ({score, misses, flicks, hit_pulse, miss_pulse, game_over, win} !==
                {6'(m_score), 6'(m_misses), 6'(m_flicks), m_hit, m_miss, m_over, m_win}) begin
                nbad++;
                $display("FAIL cycle t=%0t: got s=%0d m=%0d f=%0d hp=%0b mp=%0b go=%0b w=%0b expected s=%0d m=%0d f=%0d hp=%0b mp=%0b go=%0b w=%0b",
                         $time, score, misses, flicks, hit_pulse, miss_pulse, game_over, win,
                         m_score, m_misses, m_flicks, m_hit, m_miss, m_over, m_win);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic [8:0] l, input logic kv, input logic [3:0] ki);
        lights = l; key_valid = kv; key_index = ki;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [5:0] tp, input logic dm);
        reset = 1'b0; lights = '0; key_valid = 1'b0; key_index = '0;
        total_points = tp; deathmatch = dm;
        @(posedge clk);
        #1;
        chk("rst_outputs", int'({score, misses, flicks, hit_pulse, miss_pulse, game_over, win}), 0);
        reset = 1'b1;
    endtask

    logic [8:0] rl;
    logic       rkv;
    logic [3:0] rki;
    int         r;

    initial begin
        #1 reset = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // total_points=0 ends the game on the first edge, as a win
        do_reset(6'd0, 1'b0);
        step(9'h000, 0, 0);
        chk("tp0_over", game_over, 1);
        chk("tp0_win", win, 1);

        // 1: hit on hole 4
        do_reset(6'd25, 1'b0);
        step(9'h010, 0, 0); step(9'h010, 0, 0);
        step(9'h010, 1, 4);
        chk("t1_hit_pulse", hit_pulse, 1);
        chk("t1_score", score, 1);
        step(9'h010, 0, 0);
        chk("t1_pulse_one_cycle", hit_pulse, 0);
        for (int i = 0; i < 6; i++) step(9'h010, 0, 0);
        step(9'h000, 0, 0);
        chk("t1_flicks", flicks, 1);
        chk("t1_misses", misses, 0);

        // 2: wrong key kills the episode, later correct key ignored
        do_reset(6'd25, 1'b0);
        step(9'h001, 0, 0); step(9'h001, 0, 0);
        step(9'h001, 1, 2);
        chk("t2_miss_pulse", miss_pulse, 1);
        step(9'h001, 1, 0);
        chk("t2_no_second_pulse", {hit_pulse, miss_pulse}, 0);
        step(9'h000, 0, 0);
        chk("t2_misses", misses, 1);
        chk("t2_score", score, 0);
        chk("t2_no_end_miss", miss_pulse, 0);

        // 3: press on the change edge credits the old episode
        do_reset(6'd25, 1'b0);
        for (int i = 0; i < 3; i++) step(9'h100, 0, 0);
        step(9'h002, 1, 8);
        chk("t3_score", score, 1);
        chk("t3_flicks", flicks, 1);
        chk("t3_hit_pulse", hit_pulse, 1);
        step(9'h002, 0, 0); step(9'h002, 0, 0);
        step(9'h000, 0, 0);
        chk("t3_new_ep_miss", misses, 1);
        chk("t3_flicks2", flicks, 2);

        // 4: full game of 25 episodes with 13 hits
        do_reset(6'd25, 1'b0);
        for (int e = 0; e < 25; e++) begin
            step(9'(1 << (e % 9)), 0, 0);
            step(9'(1 << (e % 9)), (e < 13), 4'(e % 9));
            step(9'h000, 0, 0);
        end
        chk("t4_over", game_over, 1);
        chk("t4_win", win, 1);
        chk("t4_misses", misses, 12);
        for (int k = 0; k < 5; k++) begin
            step(9'(1 << k), 1, 4'(k));
            step(9'h000, 0, 0);
        end
        chk("t4_score_frozen", score, 13);
        chk("t4_flicks_frozen", flicks, 25);

        // 5: deathmatch first miss ends the game
        do_reset(6'd25, 1'b1);
        for (int i = 0; i < 3; i++) step(9'h020, 0, 0);
        step(9'h000, 0, 0);
        chk("t5_misses", misses, 1);
        chk("t5_over", game_over, 1);
        chk("t5_win", win, 0);

        // 6: asynchronous reset mid-episode, out-of-range keys ignored
        do_reset(6'd50, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(9'(1 << i), 0, 0);
            step(9'(1 << i), 1, 4'(i));
            step(9'h000, 0, 0);
        end
        chk("t6_score5", score, 5);
        step(9'h008, 0, 0); step(9'h008, 0, 0);
        #2 reset = 1'b0;
        #1;
        chk("t6_async_clear", int'({score, misses, flicks, game_over, win}), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int j = 0; j < 6; j++) step(9'h008, 1, 4'(9 + j));
        chk("t6_bad_keys_score", score, 0);
        chk("t6_bad_keys_misses", misses, 0);
        step(9'h000, 0, 0);

        // Randomized games
        for (int g = 0; g < 12; g++) begin
            do_reset((g == 0) ? 6'd0 : 6'($urandom_range(1, 20)), ($urandom_range(0, 3) == 0));
            rl = '0;
            for (int s = 0; s < 150; s++) begin
                if ($urandom_range(0, 4) == 0) begin
                    r = $urandom_range(0, 9);
                    if (r < 6)      rl = 9'(1 << $urandom_range(0, 8));
                    else if (r < 8) rl = '0;
                    else            rl = 9'($urandom);
                end
                rkv = ($urandom_range(0, 2) == 0);
                if (lit_idx(rl) >= 0 && $urandom_range(0, 1) == 1) rki = 4'(lit_idx(rl));
                else                                               rki = 4'($urandom_range(0, 15));
                step(rl, rkv, rki);
            end
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
